// File: rtl/regfile_write_buffer.sv
// Posted-write FIFO in front of the register file write port, with newest-wins read bypass.
// Define REGFILE_WRITE_BUFFER_BYPASS_EN to build the bypass; otherwise reads pass straight through.
module regfile_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [AW-1:0]            InRegister,
  input  logic [WIDTH-1:0]         InData,
  input  logic                     Stall,
  output logic                     RegWrite,
  output logic [AW-1:0]            WriteRegister,
  output logic [WIDTH-1:0]         WriteData,
  input  logic [AW-1:0]            LookupRegister1,
  input  logic [AW-1:0]            LookupRegister2,
  input  logic [WIDTH-1:0]         RegData1,
  input  logic [WIDTH-1:0]         RegData2,
  output logic [WIDTH-1:0]         ReadData1,
  output logic [WIDTH-1:0]         ReadData2,
  output logic                     Hit1,
  output logic                     Hit2,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    mem_reg  [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             accept;
  logic             store;
  logic             pop;

  assign InReady       = (count < CW'(DEPTH));
  assign Empty         = (count == '0);
  assign Count         = count;
  assign RegWrite      = !Empty && !Stall;
  assign WriteRegister = mem_reg[head];
  assign WriteData     = mem_data[head];

  assign accept = InValid && InReady;
  // Writes to register 0 complete the handshake but are dropped here.
  assign store  = accept && (InRegister != '0);
  assign pop    = RegWrite;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_reg[i]  <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (store) begin
        mem_reg[tail]  <= InRegister;
        mem_data[tail] <= InData;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
  logic [AW-1:0]    look    [2];
  logic [WIDTH-1:0] rf_data [2];
  logic [WIDTH-1:0] rd      [2];
  logic             hit     [2];

  assign look[0]    = LookupRegister1;
  assign look[1]    = LookupRegister2;
  assign rf_data[0] = RegData1;
  assign rf_data[1] = RegData2;
  assign ReadData1  = rd[0];
  assign ReadData2  = rd[1];
  assign Hit1       = hit[0];
  assign Hit2       = hit[1];

  // Scan oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      hit[p] = 1'b0;
      rd[p]  = rf_data[p];
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && (look[p] != '0) &&
            (mem_reg[head + PW'(i)] == look[p])) begin
          hit[p] = 1'b1;
          rd[p]  = mem_data[head + PW'(i)];
        end
      end
    end
  end
`else
  logic unused_lookup;

  assign Hit1          = 1'b0;
  assign Hit2          = 1'b0;
  assign ReadData1     = RegData1;
  assign ReadData2     = RegData2;
  assign unused_lookup = ^{LookupRegister1, LookupRegister2};
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed self-checking bench for regfile_write_buffer; expectations follow REGFILE_WRITE_BUFFER_BYPASS_EN.
module tb_regfile_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;
`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [AW-1:0]    InRegister;
  logic [WIDTH-1:0] InData;
  logic             Stall;
  logic             RegWrite;
  logic [AW-1:0]    WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [AW-1:0]    LookupRegister1;
  logic [AW-1:0]    LookupRegister2;
  logic [WIDTH-1:0] RegData1;
  logic [WIDTH-1:0] RegData2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             Hit1;
  logic             Hit2;
  logic [2:0]       Count;
  logic             Empty;

  int checks = 0;
  int errors = 0;
  logic [AW+WIDTH-1:0] wlog[$];

  regfile_write_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .Stall(Stall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .LookupRegister1(LookupRegister1), .LookupRegister2(LookupRegister2),
    .RegData1(RegData1), .RegData2(RegData2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Hit1(Hit1), .Hit2(Hit2), .Count(Count), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  // Record every commit the register file would see.
  always @(posedge Clk) begin
    if (RegWrite) wlog.push_back({WriteRegister, WriteData});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] r, input logic [WIDTH-1:0] d);
    InValid    = 1'b1;
    InRegister = r;
    InData     = d;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [AW-1:0] r,
                           input logic [WIDTH-1:0] d);
    logic [AW+WIDTH-1:0] e;
    e = (idx < wlog.size()) ? wlog[idx] : 'x;
    check(tag, 64'(e), 64'({r, d}));
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InRegister = '0; InData = '0; Stall = 1'b0;
    LookupRegister1 = '0; LookupRegister2 = '0;
    RegData1 = 32'h1111_1111; RegData2 = 32'h2222_2222;
    #12;
    check("rst_count", 64'(Count), 64'd0);
    check("rst_empty", 64'(Empty), 64'd1);
    check("rst_ready", 64'(InReady), 64'd1);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_hit1", 64'(Hit1), 64'd0);
    check("rst_hit2", 64'(Hit2), 64'd0);
    check("rst_rd1", 64'(ReadData1), 64'h1111_1111);
    check("rst_wreg", 64'(WriteRegister), 64'd0);
    check("rst_wdata", 64'(WriteData), 64'd0);
    Reset = 1'b0;
    step();

    // Basic retire
    offer(5'd5, 32'hDEAD_BEEF);
    step();
    InValid = 1'b0;
    LookupRegister1 = 5'd5;
    check("t1_regwrite", 64'(RegWrite), 64'd1);
    check("t1_wreg", 64'(WriteRegister), 64'd5);
    check("t1_wdata", 64'(WriteData), 64'hDEAD_BEEF);
    check("t1_count", 64'(Count), 64'd1);
    check("t1_hit1", 64'(Hit1), 64'(BYP));
    check("t1_rd1", 64'(ReadData1), BYP ? 64'hDEAD_BEEF : 64'h1111_1111);
    step();
    check("t1_empty", 64'(Empty), 64'd1);
    check("t1_regwrite_off", 64'(RegWrite), 64'd0);
    check("t1_log_n", 64'(wlog.size()), 64'd1);
    check_log("t1_log0", 0, 5'd5, 32'hDEAD_BEEF);

    // Stall and full
    wlog.delete();
    Stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      offer(AW'(k), 32'h100 + 32'(k));
      check($sformatf("t2_ready%0d", k), 64'(InReady), (k <= 4) ? 64'd1 : 64'd0);
      step();
    end
    check("t2_count_full", 64'(Count), 64'd4);
    check("t2_ready_full", 64'(InReady), 64'd0);
    check("t2_regwrite_stall", 64'(RegWrite), 64'd0);
    Stall = 1'b0;
    #1;
    check("t2_regwrite_go", 64'(RegWrite), 64'd1);
    check("t2_head", 64'(WriteRegister), 64'd1);
    check("t2_ready_poppending", 64'(InReady), 64'd0);
    step();
    check("t2_count_a", 64'(Count), 64'd3);
    check("t2_ready_a", 64'(InReady), 64'd1);
    step();
    InValid = 1'b0;
    check("t2_count_b", 64'(Count), 64'd3);
    step(); step(); step();
    check("t2_empty", 64'(Empty), 64'd1);
    check("t2_log_n", 64'(wlog.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      check_log($sformatf("t2_log%0d", k), k, AW'(k + 1), 32'h101 + 32'(k));

    // Newest-wins bypass
    wlog.delete();
    Stall = 1'b1;
    offer(5'd7, 32'd1); step();
    offer(5'd7, 32'd2); step();
    InValid = 1'b0;
    LookupRegister1 = 5'd7; RegData1 = 32'h55;
    LookupRegister2 = 5'd7; RegData2 = 32'h66;
    #1;
    check("t3_count", 64'(Count), 64'd2);
    check("t3_hit1", 64'(Hit1), 64'(BYP));
    check("t3_rd1", 64'(ReadData1), BYP ? 64'd2 : 64'h55);
    check("t3_hit2", 64'(Hit2), 64'(BYP));
    check("t3_rd2", 64'(ReadData2), BYP ? 64'd2 : 64'h66);
    LookupRegister1 = 5'd8;
    #1;
    check("t3_miss_hit1", 64'(Hit1), 64'd0);
    check("t3_miss_rd1", 64'(ReadData1), 64'h55);
    LookupRegister1 = 5'd7;
    Stall = 1'b0;
    step();
    check("t3_hit1_after_pop", 64'(Hit1), 64'(BYP));
    check("t3_rd1_after_pop", 64'(ReadData1), BYP ? 64'd2 : 64'h55);
    step();
    check("t3_hit1_drained", 64'(Hit1), 64'd0);
    check("t3_rd1_drained", 64'(ReadData1), 64'h55);
    check("t3_log_n", 64'(wlog.size()), 64'd2);
    check_log("t3_log0", 0, 5'd7, 32'd1);
    check_log("t3_log1", 1, 5'd7, 32'd2);

    // Register 0
    wlog.delete();
    offer(5'd0, 32'hFFFF_FFFF);
    check("t4_ready", 64'(InReady), 64'd1);
    step();
    InValid = 1'b0;
    LookupRegister2 = 5'd0;
    #1;
    check("t4_count", 64'(Count), 64'd0);
    check("t4_regwrite", 64'(RegWrite), 64'd0);
    check("t4_hit2", 64'(Hit2), 64'd0);
    check("t4_rd2", 64'(ReadData2), 64'h66);
    step();
    check("t4_log_n", 64'(wlog.size()), 64'd0);

    // Simultaneous accept and pop across pointer wrap
    wlog.delete();
    Stall = 1'b1;
    offer(5'd10, 32'hA0); step();
    offer(5'd11, 32'hB0); step();
    Stall = 1'b0;
    offer(5'd12, 32'hC0);
    check("t5_head_a", 64'(WriteRegister), 64'd10);
    step();
    check("t5_count_c", 64'(Count), 64'd2);
    offer(5'd13, 32'hD0); step();
    check("t5_count_d", 64'(Count), 64'd2);
    offer(5'd14, 32'hE0); step();
    InValid = 1'b0;
    LookupRegister1 = 5'd14;
    #1;
    check("t5_count_e", 64'(Count), 64'd2);
    check("t5_hit1_wrap", 64'(Hit1), 64'(BYP));
    check("t5_rd1_wrap", 64'(ReadData1), BYP ? 64'hE0 : 64'h55);
    step(); step();
    check("t5_empty", 64'(Empty), 64'd1);
    check("t5_log_n", 64'(wlog.size()), 64'd5);
    check_log("t5_log0", 0, 5'd10, 32'hA0);
    check_log("t5_log1", 1, 5'd11, 32'hB0);
    check_log("t5_log2", 2, 5'd12, 32'hC0);
    check_log("t5_log3", 3, 5'd13, 32'hD0);
    check_log("t5_log4", 4, 5'd14, 32'hE0);

    // Reset mid-operation
    Stall = 1'b1;
    offer(5'd20, 32'h20); step();
    offer(5'd21, 32'h21); step();
    offer(5'd22, 32'h22); step();
    InValid = 1'b0;
    check("t6_count_pre", 64'(Count), 64'd3);
    wlog.delete();
    #3;
    Reset = 1'b1;
    Stall = 1'b0;
    LookupRegister1 = 5'd20;
    LookupRegister2 = 5'd22;
    #1;
    check("t6_count", 64'(Count), 64'd0);
    check("t6_regwrite", 64'(RegWrite), 64'd0);
    check("t6_hit1", 64'(Hit1), 64'd0);
    check("t6_hit2", 64'(Hit2), 64'd0);
    check("t6_rd1", 64'(ReadData1), 64'h55);
    check("t6_ready", 64'(InReady), 64'd1);
    check("t6_wreg", 64'(WriteRegister), 64'd0);
    check("t6_wdata", 64'(WriteData), 64'd0);
    step();
    Reset = 1'b0;
    step(); step(); step();
    check("t6_log_n", 64'(wlog.size()), 64'd0);
    check("t6_empty", 64'(Empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
